// File: rtl/cpu_run_ctrl.sv
// CPU run controller: turns a divide-by-DIV_N slot into a one-clk cpu_ce, with run/step/burst modes, PC breakpoint and syscall stall.
// cpu_ce is combinational from registered state; launch at edge T gives the first enable in cycle T+DIV_N.
module cpu_run_ctrl #(
    parameter int unsigned DIV_N      = 4,
    parameter int unsigned PC_W       = 10,
    parameter int unsigned BURST_W    = 16,
    parameter int unsigned CNT_W      = 32,
    parameter bit          SYSC_STALL = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               cpu_wake_i,
    input  logic               cpu_slep_i,
    input  logic [1:0]         mode_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               halt_i,
    input  logic               syscall_i,
    input  logic               sysc_ack_i,
    input  logic               bp_en_i,
    input  logic [PC_W-1:0]    bp_addr_i,
    input  logic [PC_W-1:0]    cpu_pc_i,
    output logic               cpu_ce_o,
    output logic               cpu_stat_o,
    output logic               sysc_mp_o,
    output logic [2:0]         state_o,
    output logic               bp_hit_o,
    output logic [CNT_W-1:0]   step_cnt_o
);

    localparam int unsigned      DIV_W    = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_BURST = 3'd3,
        ST_SYSC  = 3'd4,
        ST_HALT  = 3'd5,
        ST_BREAK = 3'd6
    } state_t;

    state_t             state_q, state_d, ret_q, ret_d, launch_st;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [BURST_W-1:0] remain_q, remain_d;
    logic               skip_q, skip_d;
    logic               syscall_q, sysc_mp_q;
    logic [CNT_W-1:0]   step_cnt_q;
    logic               run_st, slot, bp_block, cpu_ce, sysc_edge, do_launch;

    assign run_st    = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_BURST);
    assign slot      = run_st && (div_cnt_q == DIV_LAST);
    assign bp_block  = bp_en_i && (cpu_pc_i == bp_addr_i) && !skip_q;
    assign cpu_ce    = slot && !bp_block;
    assign sysc_edge = syscall_i && !syscall_q;

    always_comb begin
        case (mode_i)
            2'b01:   launch_st = ST_STEP;
            2'b10:   launch_st = (burst_len_i != '0) ? ST_BURST : ST_IDLE;
            default: launch_st = ST_RUN;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        remain_d  = remain_q;
        skip_d    = skip_q;
        do_launch = 1'b0;
        if (cpu_ce && (state_q == ST_BURST)) remain_d = remain_q - 1'b1;
        if (cpu_ce) skip_d = 1'b0;
        case (state_q)
            ST_IDLE: do_launch = start_i || cpu_wake_i;
            ST_RUN, ST_STEP, ST_BURST: begin
                if (halt_i) begin
                    state_d = ST_HALT;
                end else if (cpu_slep_i) begin
                    state_d = ST_IDLE;
                end else if (SYSC_STALL && sysc_edge) begin
                    state_d = ST_SYSC;
                    if (state_q == ST_RUN)   ret_d = ST_RUN;
                    else if (remain_d != '0) ret_d = ST_BURST;
                    else                     ret_d = ST_IDLE;
                end else if (slot && bp_block) begin
                    state_d = ST_BREAK;
                end else if (cpu_ce && (state_q == ST_STEP)) begin
                    state_d = ST_IDLE;
                end else if (cpu_ce && (state_q == ST_BURST) && (remain_q == BURST_W'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYSC: begin
                if (halt_i)          state_d = ST_HALT;
                else if (cpu_slep_i) state_d = ST_IDLE;
                else if (sysc_ack_i) state_d = ret_q;
            end
            ST_HALT: do_launch = start_i && !halt_i;
            ST_BREAK: begin
                do_launch = start_i || cpu_wake_i;
                // Resume must let the instruction sitting on the breakpoint execute once.
                if (do_launch && (launch_st != ST_IDLE)) skip_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (do_launch) begin
            state_d  = launch_st;
            remain_d = (launch_st == ST_BURST) ? burst_len_i : '0;
        end
    end

    // Divider restarts on any entry into a run state, including return from SYSC.
    always_comb begin
        div_cnt_d = '0;
        if (run_st && (state_d == state_q))
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            ret_q      <= ST_IDLE;
            div_cnt_q  <= '0;
            remain_q   <= '0;
            skip_q     <= 1'b0;
            syscall_q  <= 1'b0;
            sysc_mp_q  <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            div_cnt_q  <= div_cnt_d;
            remain_q   <= remain_d;
            skip_q     <= skip_d;
            syscall_q  <= syscall_i;
            sysc_mp_q  <= sysc_edge;
            step_cnt_q <= step_cnt_q + CNT_W'(cpu_ce);
        end
    end

    assign cpu_ce_o   = cpu_ce;
    assign cpu_stat_o = run_st;
    assign sysc_mp_o  = sysc_mp_q;
    assign state_o    = state_q;
    assign bp_hit_o   = (state_q == ST_BREAK);
    assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DIV_N=4 and syscall stall enabled.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, cpu_wake, cpu_slep, halt, syscall, sysc_ack, bp_en;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic [9:0]  bp_addr, cpu_pc;
    logic        cpu_ce, cpu_stat, sysc_mp, bp_hit;
    logic [2:0]  state;
    logic [31:0] step_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ce  = 0;
    bit pc_follow = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .DIV_N(4), .PC_W(10), .BURST_W(16), .CNT_W(32), .SYSC_STALL(1'b1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cpu_wake_i(cpu_wake),
        .cpu_slep_i(cpu_slep), .mode_i(mode), .burst_len_i(burst_len), .halt_i(halt),
        .syscall_i(syscall), .sysc_ack_i(sysc_ack), .bp_en_i(bp_en), .bp_addr_i(bp_addr),
        .cpu_pc_i(cpu_pc), .cpu_ce_o(cpu_ce), .cpu_stat_o(cpu_stat), .sysc_mp_o(sysc_mp),
        .state_o(state), .bp_hit_o(bp_hit), .step_cnt_o(step_cnt)
    );

    typedef struct {
        logic        start, wake, slep;
        logic [1:0]  mode;
        logic        ce;
        logic [2:0]  st;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic s, input logic w, input logic sl, input logic [1:0] m,
                                input logic ce, input logic [2:0] st, input logic [31:0] cnt);
        vec_t v;
        v.start = s; v.wake = w; v.slep = sl; v.mode = m; v.ce = ce; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle with the inputs currently applied; the bench CPU advances its PC on each enable.
    task automatic run_cycle();
        logic ce_s;
        ce_s = cpu_ce;
        if (ce_s) n_ce++;
        @(posedge clk);
        #1;
        if (pc_follow && ce_s) cpu_pc = cpu_pc + 10'd1;
    endtask

    task automatic clear_inputs();
        start = 0; cpu_wake = 0; cpu_slep = 0; halt = 0; syscall = 0; sysc_ack = 0;
        bp_en = 0; mode = 2'b00; burst_len = '0; bp_addr = '0; cpu_pc = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        pc_follow = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_ce = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check("rst_state", state, 3'd0);
        check("rst_ce", cpu_ce, 1'b0);
        check("rst_stat", cpu_stat, 1'b0);
        check("rst_mp", sysc_mp, 1'b0);
        check("rst_bp_hit", bp_hit, 1'b0);
        check("rst_cnt", step_cnt, 32'd0);
        do_reset();

        // Free-run from cycle 0, sleep at 13, then wake+sleep together launches a single step.
        tbl[0]  = mk(1, 0, 0, 2'b00, 0, 3'd0, 0);
        tbl[1]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 0);
        tbl[2]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 0);
        tbl[3]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 0);
        tbl[4]  = mk(0, 0, 0, 2'b00, 1, 3'd1, 0);
        tbl[5]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 1);
        tbl[6]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 1);
        tbl[7]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 1);
        tbl[8]  = mk(0, 0, 0, 2'b00, 1, 3'd1, 1);
        tbl[9]  = mk(0, 0, 0, 2'b00, 0, 3'd1, 2);
        tbl[10] = mk(0, 0, 0, 2'b00, 0, 3'd1, 2);
        tbl[11] = mk(0, 0, 0, 2'b00, 0, 3'd1, 2);
        tbl[12] = mk(0, 0, 0, 2'b00, 1, 3'd1, 2);
        tbl[13] = mk(0, 0, 1, 2'b00, 0, 3'd1, 3);
        tbl[14] = mk(0, 0, 0, 2'b00, 0, 3'd0, 3);
        tbl[15] = mk(0, 1, 1, 2'b01, 0, 3'd0, 3);
        tbl[16] = mk(0, 0, 0, 2'b00, 0, 3'd2, 3);
        tbl[17] = mk(0, 0, 0, 2'b00, 0, 3'd2, 3);
        tbl[18] = mk(0, 0, 0, 2'b00, 0, 3'd2, 3);
        tbl[19] = mk(0, 0, 0, 2'b00, 1, 3'd2, 3);
        tbl[20] = mk(0, 0, 0, 2'b00, 0, 3'd0, 4);
        for (int i = 0; i < 21; i++) begin
            start = tbl[i].start; cpu_wake = tbl[i].wake; cpu_slep = tbl[i].slep; mode = tbl[i].mode;
            #1;
            check($sformatf("tbl[%0d].ce", i), cpu_ce, tbl[i].ce);
            check($sformatf("tbl[%0d].state", i), state, tbl[i].st);
            check($sformatf("tbl[%0d].cnt", i), step_cnt, tbl[i].cnt);
            @(posedge clk);
            #1;
        end

        // Burst of 5: enables at cycles 4..20, back to IDLE after the last.
        do_reset();
        mode = 2'b10; burst_len = 16'd5; start = 1;
        run_cycle();
        start = 0;
        check("burst_state", state, 3'd3);
        k = 1;
        for (int c = 1; c < 31; c++) begin
            if (cpu_ce) k = c;
            run_cycle();
        end
        check("burst_n_ce", n_ce, 5);
        check("burst_last_ce_cycle", k, 20);
        check("burst_end_state", state, 3'd0);
        check("burst_cnt", step_cnt, 32'd5);

        burst_len = 16'd0; start = 1; n_ce = 0;
        run_cycle();
        start = 0;
        check("burst0_state", state, 3'd0);
        for (int c = 0; c < 8; c++) run_cycle();
        check("burst0_n_ce", n_ce, 0);
        check("burst0_cnt", step_cnt, 32'd5);

        // Three single steps spaced 10 cycles apart.
        do_reset();
        mode = 2'b01;
        for (int p = 0; p < 3; p++) begin
            start = 1;
            run_cycle();
            start = 0;
            check($sformatf("step%0d_state", p), state, 3'd2);
            for (int c = 0; c < 9; c++) run_cycle();
            check($sformatf("step%0d_idle", p), state, 3'd0);
        end
        check("step_n_ce", n_ce, 3);
        check("step_cnt", step_cnt, 32'd3);

        // Breakpoint at 0x010 with the bench CPU stepping its PC on every enable.
        do_reset();
        bp_en = 1; bp_addr = 10'h010; cpu_pc = 10'h00E; pc_follow = 1'b1; mode = 2'b00; start = 1;
        run_cycle();
        start = 0;
        k = 1;
        while (state != 3'd6 && k < 60) begin
            run_cycle();
            k++;
        end
        check("bp_break_cycle", k, 13);
        check("bp_state", state, 3'd6);
        check("bp_hit", bp_hit, 1'b1);
        check("bp_pc", cpu_pc, 10'h010);
        check("bp_n_ce", n_ce, 2);
        for (int c = 0; c < 5; c++) run_cycle();
        check("bp_hold_n_ce", n_ce, 2);
        check("bp_hold_state", state, 3'd6);
        start = 1;
        run_cycle();
        start = 0;
        check("bp_resume_state", state, 3'd1);
        check("bp_resume_hit", bp_hit, 1'b0);
        k = 0;
        while (!cpu_ce && k < 20) begin
            run_cycle();
            k++;
        end
        check("bp_resume_wait", k, 3);
        check("bp_resume_ce", cpu_ce, 1'b1);
        check("bp_resume_pc", cpu_pc, 10'h010);
        run_cycle();
        k = 0;
        while (!cpu_ce && k < 20) begin
            run_cycle();
            k++;
        end
        check("bp_next_ce", cpu_ce, 1'b1);
        check("bp_next_pc", cpu_pc, 10'h011);
        check("bp_next_state", state, 3'd1);
        pc_follow = 1'b0;

        // Syscall pulse in IDLE, stall in RUN, ack, halt out of SYSC and HALT exit rules.
        do_reset();
        syscall = 1;
        run_cycle();
        check("mp_idle_pulse", sysc_mp, 1'b1);
        check("mp_idle_state", state, 3'd0);
        syscall = 0;
        run_cycle();
        check("mp_idle_drop", sysc_mp, 1'b0);
        mode = 2'b00; start = 1;
        run_cycle();
        start = 0;
        for (int c = 0; c < 4; c++) run_cycle();
        check("sysc_pre_n_ce", n_ce, 1);
        syscall = 1;
        run_cycle();
        check("sysc_mp", sysc_mp, 1'b1);
        check("sysc_state", state, 3'd4);
        run_cycle();
        check("sysc_mp_once", sysc_mp, 1'b0);
        for (int c = 0; c < 6; c++) run_cycle();
        check("sysc_stall_n_ce", n_ce, 1);
        check("sysc_stall_state", state, 3'd4);
        syscall = 0; sysc_ack = 1;
        run_cycle();
        sysc_ack = 0;
        check("sysc_ack_state", state, 3'd1);
        k = 0;
        while (!cpu_ce && k < 10) begin
            run_cycle();
            k++;
        end
        check("sysc_ack_ce_wait", k, 3);
        syscall = 1;
        run_cycle();
        check("sysc2_state", state, 3'd4);
        halt = 1;
        run_cycle();
        check("halt_state", state, 3'd5);
        check("halt_stat", cpu_stat, 1'b0);
        cpu_wake = 1;
        run_cycle();
        cpu_wake = 0;
        check("halt_wake_ignored", state, 3'd5);
        start = 1;
        run_cycle();
        check("halt_start_blocked", state, 3'd5);
        halt = 0;
        run_cycle();
        start = 0;
        check("halt_exit_state", state, 3'd1);
        check("halt_exit_stat", cpu_stat, 1'b1);
        halt = 1; cpu_slep = 1;
        run_cycle();
        check("halt_over_slep", state, 3'd5);
        halt = 0; cpu_slep = 0; syscall = 0;

        // Asynchronous reset in the middle of a burst.
        do_reset();
        mode = 2'b10; burst_len = 16'd10; start = 1;
        run_cycle();
        start = 0;
        k = 0;
        while (!cpu_ce && k < 10) begin
            run_cycle();
            k++;
        end
        run_cycle();
        k = 0;
        while (!cpu_ce && k < 10) begin
            run_cycle();
            k++;
        end
        check("mid_ce_before_rst", cpu_ce, 1'b1);
        check("mid_cnt_before_rst", step_cnt, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ce", cpu_ce, 1'b0);
        check("mid_rst_state", state, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_ce = 0;
        for (int c = 0; c < 6; c++) run_cycle();
        check("post_rst_state", state, 3'd0);
        check("post_rst_cnt", step_cnt, 32'd0);
        check("post_rst_n_ce", n_ce, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Parametrised CPU run controller sitting between the system shell and the CPU top. It replaces the gated CPU clock with a single-cycle clock-enable (`cpu_ce`) generated from a divide-by-`DIV_N` counter. It adds free-run, single-step and N-step burst modes, a PC breakpoint with resume-skip, and syscall stall/acknowledge on top of the existing wake/sleep/halt control and syscall mono-pulse.

## Interface
- `DIV_N`, 4: `cpu_ce` period in `clk` cycles; legal range ≥1.
- `PC_W`, 10: width of `cpu_pc` / `bp_addr`.
- `BURST_W`, 16: width of `burst_len`.
- `CNT_W`, 32: width of `step_cnt`.
- `SYSC_STALL`, 1: 1 = syscall edge stalls the CPU until `sysc_ack`; 0 = pulse only.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  launch in the selected mode (also leaves HALT/BREAK).
- `cpu_wake`  in  1  launch in the selected mode (IDLE/BREAK only).
- `cpu_slep`  in  1  stop to IDLE.
- `mode`  in  2  00/11 free-run, 01 single-step, 10 burst.
- `burst_len`  in  BURST_W  number of enables in burst mode; sampled on launch.
- `halt`  in  1  CPU halt level.
- `syscall`  in  1  CPU syscall level.
- `sysc_ack`  in  1  system done servicing syscall.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  PC_W  breakpoint address.
- `cpu_pc`  in  PC_W  current CPU PC.
- `cpu_ce`  out  1  CPU clock-enable, one `clk` wide.
- `cpu_stat`  out  1  high in RUN/STEP/BURST.
- `sysc_mp`  out  1  one-cycle pulse on syscall rising edge.
- `state`  out  3  FSM state code.
- `bp_hit`  out  1  high while in BREAK.
- `step_cnt`  out  CNT_W  count of issued `cpu_ce`.

## Operation
- States (code): IDLE 0, RUN 1, STEP 2, BURST 3, SYSC 4, HALT 5, BREAK 6.
- Launch (`start` or `cpu_wake`, evaluated in IDLE):
  - mode 00/11 → RUN.
  - mode 01 → STEP.
  - mode 10 → BURST with `remain <= burst_len`; if `burst_len`=0, stay in IDLE.
- Divider: `div_cnt` is cleared on every entry into RUN/STEP/BURST and counts 0..DIV_N-1, wrapping.
- `cpu_ce` = run state && `div_cnt`==DIV_N-1 && !bp_block. Combinational from registered state.
- `bp_block` = `bp_en` && `cpu_pc`==`bp_addr` && !`skip`. When `bp_block` is high at the enable slot, the enable is suppressed and the FSM goes to BREAK.
- `skip` is set on launch out of BREAK and cleared by the first `cpu_ce`. This lets resume execute the breakpoint instruction.
- STEP: after one `cpu_ce` → IDLE.
- BURST: each `cpu_ce` decrements `remain`; the enable that takes `remain` 1→0 returns the FSM to IDLE.
- Syscall: `sysc_mp` = `syscall` && !`syscall_q`, with `syscall_q` reset to 0. It pulses in every state.
  - SYSC_STALL=1 and the edge occurs in a run state → SYSC. The return state is RUN if from RUN, BURST if `remain`>0, else IDLE.
  - `sysc_ack` in SYSC → return state; `div_cnt` is cleared.
- `halt` high in any run state or SYSC → HALT. HALT leaves only on `start` with `halt` low (launch per mode); `cpu_wake` is ignored there.
- `cpu_slep` in a run state or SYSC → IDLE.
- Same-edge priority in run states: `halt` > `cpu_slep` > syscall edge > breakpoint > STEP/BURST completion.
- In IDLE, `start`/`cpu_wake` beat a simultaneous `cpu_slep`.
- `step_cnt` increments on every `cpu_ce` and wraps modulo 2^CNT_W.

## Timing
- Reset (async): state IDLE; `cpu_ce`, `cpu_stat`, `sysc_mp`, `bp_hit` = 0; `step_cnt`, `div_cnt`, `remain`, `skip`, `syscall_q` = 0.
- Reset asserted mid-operation drops `cpu_ce` immediately. No enable is issued in the cycle reset is released.
- Launch sampled at edge T → state valid T+1 → first `cpu_ce` in cycle T+DIV_N. With DIV_N=1, `cpu_ce` is high every cycle from T+1.
- `cpu_ce` high in the same cycle as `cpu_slep`/`halt` is still issued; the state changes at the following edge.
- `sysc_mp` is high in the cycle after the edge on which `syscall` is first sampled high. SYSC is entered on that same edge.
- `bp_hit` rises one cycle after the suppressed slot.

## Test plan
- DIV_N=4, mode 00, `start` pulse at cycle 0 → `cpu_ce` at cycles 4, 8, 12. `cpu_slep` at cycle 13 → IDLE; `step_cnt`=3.
- Mode 10, `burst_len`=5 → exactly 5 `cpu_ce` pulses, then IDLE; `step_cnt`=5. `burst_len`=0 → state stays 0 and no `cpu_ce`.
- Mode 01, three `start` pulses spaced 10 cycles → three `cpu_ce` pulses; state 2→0 after each.
- `bp_en`=1, `bp_addr`=0x010, PC reaches 0x010 → no enable, state 6, `bp_hit`=1. `start` → next `cpu_ce` issued with PC 0x010, then run continues.
- SYSC_STALL=1, `syscall` rises during RUN → `sysc_mp` high 1 cycle, state 4, no `cpu_ce`. `sysc_ack` → RUN, enable after DIV_N cycles. `halt` during SYSC → HALT; `cpu_wake` ignored; `start` with `halt`=0 → RUN.
- `rst`=0 asserted mid-burst → `cpu_ce`=0 within the cycle. After release: state 0, `step_cnt`=0.
